button_conditioner: RTL

Input conditioning stage between the four raw colour buttons (ui_in[3:0]) and the colour decoder / WAIT stage.
- Synchronises and debounces each button.
- Enforces one-press-at-a-time.
- Emits a single-cycle press event carrying the 2-bit colour code. WAIT consumes this in place of the raw "any button" OR, so one physical press registers exactly once.

---
 rtl/simon_pkg.sv | 19 +
 rtl/button_conditioner_if.sv | 12 +
 rtl/btn_debounce.sv | 30 +++
 rtl/button_conditioner.sv | 64 ++++++
 4 files changed

// File: rtl/simon_pkg.sv
// simon_pkg: colour codes, FSM states and one-hot helpers shared by the button path.
package simon_pkg;
  localparam int NUM_BUTTONS = 4;
  localparam logic [1:0] COL_RED   = 2'b00;
  localparam logic [1:0] COL_GREEN = 2'b01;
  localparam logic [1:0] COL_BLUE  = 2'b10;
  localparam logic [1:0] COL_3     = 2'b11;
  typedef enum logic {IDLE, HELD} state_t;
  function automatic logic is_onehot(logic [NUM_BUTTONS-1:0] v);
    return v != '0 && (v & (v - 1'b1)) == '0;
  endfunction
  // OR of set-bit indices: exact for one-hot input, no priority chain
  function automatic logic [1:0] onehot_to_bin(logic [NUM_BUTTONS-1:0] v);
    logic [1:0] b;
    b = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) b |= v[i] ? 2'(i) : 2'b00;
    return b;
  endfunction
endpackage

// File: rtl/button_conditioner_if.sv
// button_conditioner_if: raw buttons in, conditioned press events out.
interface button_conditioner_if;
  import simon_pkg::*;
  logic [NUM_BUTTONS-1:0] btn_raw;
  logic                   press_valid;
  logic [1:0]             press_colour;
  logic                   btn_busy;
  logic                   multi_err;
  logic                   btn_stuck;
  modport master(output btn_raw, input press_valid, press_colour, btn_busy, multi_err, btn_stuck);
  modport slave(input btn_raw, output press_valid, press_colour, btn_busy, multi_err, btn_stuck);
endinterface

// File: rtl/btn_debounce.sv
// btn_debounce: 2-FF synchroniser plus stable-count debouncer for one button.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  output logic o_deb
);
  logic             r_s1, r_s2, r_deb;
  logic [CNT_W-1:0] r_cnt;
  logic             w_diff, w_done;
  assign w_diff = r_s2 != r_deb;
  assign w_done = w_diff && r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1);
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1  <= 1'b0;
      r_s2  <= 1'b0;
      r_deb <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_s1  <= i_raw;
      r_s2  <= r_s1;
      r_deb <= w_done ? r_s2 : r_deb;
      r_cnt <= (w_diff && !w_done) ? r_cnt + 1'b1 : '0;
    end
  end
  assign o_deb = r_deb;
endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: debounced one-press-at-a-time colour events.
// Define BTN_STUCK_TIMEOUT_EN to enable the stuck-button hold timer.
module button_conditioner
  import simon_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 16,
  parameter int STUCK_CYCLES    = 65535
) (
  input logic                clk,
  input logic                reset,
  button_conditioner_if.slave bus
);
  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES >= (1 << CNT_W) || STUCK_CYCLES >= (1 << CNT_W)) begin : g_bad_cfg
    $error("button_conditioner: counter width too small for configured cycle counts");
  end
  logic [NUM_BUTTONS-1:0] w_deb;
  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb (
      .clk   (clk),
      .reset (reset),
      .i_raw (bus.btn_raw[i]),
      .o_deb (w_deb[i])
    );
  end
  state_t     r_state, w_next;
  logic       w_accept, w_multi;
  logic       r_press_valid, r_multi_err;
  logic [1:0] r_colour;
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end
  always_comb begin
    w_accept = r_state == IDLE && is_onehot(w_deb);
    w_multi  = r_state == IDLE && w_deb != '0 && !is_onehot(w_deb);
    w_next   = r_state == IDLE ? (w_deb != '0 ? HELD : IDLE) : (w_deb == '0 ? IDLE : HELD);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_press_valid <= 1'b0;
      r_multi_err   <= 1'b0;
      r_colour      <= COL_RED;
    end else begin
      r_press_valid <= w_accept;
      r_multi_err   <= w_multi;
      r_colour      <= w_accept ? onehot_to_bin(w_deb) : r_colour;
    end
  end
  assign bus.press_valid  = r_press_valid;
  assign bus.multi_err    = r_multi_err;
  assign bus.press_colour = r_colour;
  assign bus.btn_busy     = r_state == HELD;
`ifdef BTN_STUCK_TIMEOUT_EN
  logic [CNT_W-1:0] r_hold;
  always_ff @(posedge clk) begin
    if (reset || r_state == IDLE) r_hold <= '0;
    else if (r_hold != '1)        r_hold <= r_hold + 1'b1;
  end
  assign bus.btn_stuck = r_state == HELD && r_hold >= CNT_W'(STUCK_CYCLES);
`else
  assign bus.btn_stuck = 1'b0;
`endif
endmodule
